// File: rtl/pf_sched_pkg.sv
// pf_sched_pkg: shared FSM state type and default parameters for the prefetch issue arbiter.
package pf_sched_pkg;
  typedef enum logic {RUN, THROTTLED} pf_state_e;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_QDEPTH = 8;
  localparam int DEF_MSHR_THRESHOLD = 2;
  localparam int DEF_STARVE_MAX = 15;
  localparam int DEF_LOGLINE = 6;
endpackage

// File: rtl/pf_request_fifo.sv
// pf_request_fifo: drop-oldest prefetch FIFO with a line-address match port over occupied entries.
module pf_request_fifo
  import pf_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int LOGLINE = DEF_LOGLINE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic [WIDTH-LOGLINE-1:0] match_line,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     dropped,
  output logic                     match
);
  localparam int PW = $clog2(QDEPTH);
  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [PW:0] count;
  logic full, do_pop;
  assign empty = count == '0;
  assign full = count == (PW+1)'(QDEPTH);
  assign do_pop = pop && !empty;
  assign dropped = push && full && !do_pop;
  assign head = mem[rptr];
  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < QDEPTH; i++)
      match = match || (({1'b0, PW'(i) - rptr} < count) && mem[i][WIDTH-1:LOGLINE] == match_line);
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= push_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (do_pop || dropped) rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(push && !dropped) - (PW+1)'(do_pop);
    end
endmodule

// File: rtl/prefetch_issue_arbiter.sv
// prefetch_issue_arbiter: demand/prefetch arbiter with MSHR throttling, anti-starvation and one output register.
// Optional PF_DEDUP_EN discards prefetches whose line is already queued or held.
module prefetch_issue_arbiter
  import pf_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int MSHR_THRESHOLD = DEF_MSHR_THRESHOLD,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int LOGLINE = DEF_LOGLINE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dem_valid_i,
  input  logic [WIDTH-1:0] dem_address_i,
  output logic             dem_ready_o,
  input  logic             pf_valid_i,
  input  logic [WIDTH-1:0] pf_address_i,
  input  logic [7:0]       mshr_free_i,
  input  logic             lo_ready_i,
  output logic             lo_valid_o,
  output logic [WIDTH-1:0] lo_address_o,
  output logic             lo_is_prefetch_o,
  output logic [15:0]      drop_count_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [8:0] TH = 9'(MSHR_THRESHOLD);
  pf_state_e state, state_nx;
  logic [SW-1:0] starve;
  logic [WIDTH-1:0] head;
  logic load, pf_ok, force_pf, take_pf, take_dem, dup, push;
  logic fifo_empty, fifo_drop, fifo_match;
  pf_request_fifo #(.WIDTH(WIDTH), .QDEPTH(QDEPTH), .LOGLINE(LOGLINE)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(pf_address_i),
    .pop(take_pf),
    .match_line(pf_address_i[WIDTH-1:LOGLINE]),
    .head(head),
    .empty(fifo_empty),
    .dropped(fifo_drop),
`ifdef PF_DEDUP_EN
    .match(fifo_match)
`else
    .match()
`endif
  );
`ifdef PF_DEDUP_EN
  assign dup = pf_valid_i && (fifo_match ||
               (lo_valid_o && lo_address_o[WIDTH-1:LOGLINE] == pf_address_i[WIDTH-1:LOGLINE]));
`else
  assign fifo_match = 1'b0;
  assign dup = fifo_match;
`endif
  assign push = pf_valid_i && !dup;
  always_comb
    state_nx = (state == RUN) ? (({1'b0, mshr_free_i} < TH) ? THROTTLED : RUN)
                              : (({1'b0, mshr_free_i} >= TH + 9'd1) ? RUN : THROTTLED);
  assign load = !lo_valid_o || lo_ready_i;
  assign pf_ok = state == RUN && !fifo_empty;
  assign force_pf = pf_ok && starve == SW'(STARVE_MAX);
  assign take_pf = load && (force_pf || (pf_ok && !dem_valid_i));
  assign take_dem = load && dem_valid_i && !force_pf;
  assign dem_ready_o = take_dem;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      starve <= '0;
      drop_count_o <= '0;
      lo_valid_o <= 1'b0;
      lo_address_o <= '0;
      lo_is_prefetch_o <= 1'b0;
    end else begin
      state <= state_nx;
      starve <= (take_pf || fifo_empty) ? '0
              : (take_dem && starve != SW'(STARVE_MAX)) ? starve + 1'b1 : starve;
      drop_count_o <= ((fifo_drop || dup) && drop_count_o != 16'hffff) ? drop_count_o + 16'd1 : drop_count_o;
      if (load) begin
        lo_valid_o <= take_pf || take_dem;
        lo_address_o <= take_pf ? head : dem_address_i;
        lo_is_prefetch_o <= take_pf;
      end
    end
endmodule

// File: tb/tb_prefetch_issue_arbiter.sv
// tb_prefetch_issue_arbiter: directed vectors with hand-computed expectations for prefetch_issue_arbiter.
module tb_prefetch_issue_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic dem_valid = 1'b0, pf_valid = 1'b0, lo_ready = 1'b1;
  logic [63:0] dem_address = '0, pf_address = '0;
  logic [7:0] mshr_free = 8'd8;
  logic dem_ready, lo_valid, lo_is_prefetch;
  logic [63:0] lo_address;
  logic [15:0] drop_count;
  int n_chk = 0, n_fail = 0;
  prefetch_issue_arbiter dut (
    .clk(clk), .rst(rst),
    .dem_valid_i(dem_valid), .dem_address_i(dem_address), .dem_ready_o(dem_ready),
    .pf_valid_i(pf_valid), .pf_address_i(pf_address),
    .mshr_free_i(mshr_free), .lo_ready_i(lo_ready),
    .lo_valid_o(lo_valid), .lo_address_o(lo_address), .lo_is_prefetch_o(lo_is_prefetch),
    .drop_count_o(drop_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [63:0] seen [$];
    int n_dem;
    bit found;
    #2;
    check("rst_valid", lo_valid, 0);
    check("rst_addr", lo_address, 0);
    check("rst_ispf", lo_is_prefetch, 0);
    check("rst_drop", drop_count, 0);
    tick();
    rst = 1'b0;
    // demand beats a same-cycle prefetch, prefetch follows
    dem_valid = 1'b1; dem_address = 64'h1000;
    pf_valid = 1'b1; pf_address = 64'h2000;
    #1 check("p1_dem_ready", dem_ready, 1);
    tick();
    dem_valid = 1'b0; pf_valid = 1'b0;
    check("p1_valid0", lo_valid, 1);
    check("p1_addr0", lo_address, 64'h1000);
    check("p1_ispf0", lo_is_prefetch, 0);
    tick();
    check("p1_addr1", lo_address, 64'h2000);
    check("p1_ispf1", lo_is_prefetch, 1);
    tick();
    check("p1_idle", lo_valid, 0);
    // overflow: nine prefetches into eight entries while throttled
    mshr_free = 8'd0;
    tick();
    for (int k = 1; k <= 9; k++) begin
      pf_valid = 1'b1; pf_address = 64'h40 * k;
      tick();
    end
    pf_valid = 1'b0;
    check("ovf_drop", drop_count, 1);
    check("ovf_no_issue", lo_valid, 0);
    mshr_free = 8'd8;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (lo_valid) seen.push_back(lo_address);
    end
    check("ovf_count", seen.size(), 8);
    for (int k = 0; k < 8 && k < seen.size(); k++) check($sformatf("ovf_q%0d", k), seen[k], 64'h40 * (k + 2));
    // hysteresis: 1 and 2 stay throttled, 3 resumes
    mshr_free = 8'd0;
    tick(); tick();
    pf_valid = 1'b1; pf_address = 64'h3000;
    tick();
    pf_valid = 1'b0;
    mshr_free = 8'd1;
    for (int c = 0; c < 3; c++) begin tick(); check("hys_m1", lo_valid, 0); end
    mshr_free = 8'd2;
    for (int c = 0; c < 3; c++) begin tick(); check("hys_m2", lo_valid, 0); end
    mshr_free = 8'd3;
    tick();
    check("hys_m3_lat", lo_valid, 0);
    tick();
    check("hys_m3_valid", lo_valid, 1);
    check("hys_m3_addr", lo_address, 64'h3000);
    tick();
    // starvation: one prefetch enqueued alongside the first of a demand stream
    dem_valid = 1'b1; dem_address = 64'h5000;
    pf_valid = 1'b1; pf_address = 64'h6000;
    tick();
    pf_valid = 1'b0;
    n_dem = 0; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (lo_valid && lo_is_prefetch) found = 1'b1;
      else begin
        if (lo_valid) n_dem++;
        tick();
      end
    end
    check("stv_found", found, 1);
    check("stv_addr", lo_address, 64'h6000);
    check("stv_demands", n_dem, 16);
    dem_valid = 1'b0;
    tick(); tick();
    // same-line prefetches
    pf_valid = 1'b1; pf_address = 64'h1000;
    tick();
    pf_address = 64'h1010;
    tick();
    pf_valid = 1'b0;
    seen.delete();
    if (lo_valid) seen.push_back(lo_address);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (lo_valid) seen.push_back(lo_address);
    end
`ifdef PF_DEDUP_EN
    check("dup_count", seen.size(), 1);
    check("dup_drop", drop_count, 2);
`else
    check("dup_count", seen.size(), 2);
    check("dup_drop", drop_count, 1);
    if (seen.size() == 2) check("dup_second", seen[1], 64'h1010);
`endif
    if (seen.size() > 0) check("dup_first", seen[0], 64'h1000);
    // reset while a request is held
    lo_ready = 1'b0;
    dem_valid = 1'b1; dem_address = 64'h7000;
    tick();
    dem_valid = 1'b0;
    pf_valid = 1'b1; pf_address = 64'h8000;
    tick();
    pf_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("hold_valid", lo_valid, 1);
      check("hold_addr", lo_address, 64'h7000);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check("arst_valid", lo_valid, 0);
    check("arst_addr", lo_address, 0);
    check("arst_ispf", lo_is_prefetch, 0);
    check("arst_drop", drop_count, 0);
    tick();
    rst = 1'b0; lo_ready = 1'b1; mshr_free = 8'd8;
    for (int c = 0; c < 3; c++) begin tick(); check("arst_qempty", lo_valid, 0); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prefetch_issue_arbiter.md
PREFETCH_ISSUE_ARBITER -- requirements
Module: prefetch_issue_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning address width.
REQ-002 SHALL have parameter QDEPTH, default 8, meaning prefetch queue entries (power of two).
REQ-003 SHALL have parameter MSHR_THRESHOLD, default 2, meaning minimum free MSHRs required to issue a prefetch.
REQ-004 SHALL have parameter STARVE_MAX, default 15, meaning demand-granted cycles before one forced prefetch grant.
REQ-005 SHALL have parameter LOGLINE, default 6, meaning line-offset bits ignored for address compare.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 dem_valid_i  input  1  demand miss request valid.
REQ-009 dem_address_i  input  WIDTH  demand miss address.
REQ-010 dem_ready_o  output  1  demand accepted this cycle.
REQ-011 pf_valid_i  input  1  prefetch request from best-offset prefetcher; no backpressure.
REQ-012 pf_address_i  input  WIDTH  prefetch address.
REQ-013 mshr_free_i  input  8  free lower-level MSHR count.
REQ-014 lo_ready_i  input  1  lower level accepts request.
REQ-015 lo_valid_o  output  1  request to lower level valid.
REQ-016 lo_address_o  output  WIDTH  request address.
REQ-017 lo_is_prefetch_o  output  1  request is a prefetch.
REQ-018 drop_count_o  output  16  saturating count of discarded prefetches.

Function
REQ-019 SHALL hold one output register; lo_valid_o/lo_address_o/lo_is_prefetch_o stable while lo_valid_o=1 and lo_ready_i=0.
REQ-020 Output register SHALL load when empty or lo_ready_i=1 (same-cycle refill allowed); one-cycle latency input to lo_valid_o.
REQ-021 dem_ready_o SHALL be 1 exactly when the register loads a demand; demand never dropped.
REQ-022 Prefetch queue SHALL be FIFO; pf_valid_i enqueues every cycle it is high.
REQ-023 Enqueue when full with no same-cycle dequeue SHALL drop the oldest entry, enqueue new, increment drop_count_o.
REQ-024 Enqueue and dequeue same cycle when full SHALL drop nothing.
REQ-025 FSM states RUN, THROTTLED: RUN->THROTTLED when mshr_free_i < MSHR_THRESHOLD; THROTTLED->RUN when mshr_free_i >= MSHR_THRESHOLD+1 (hysteresis).
REQ-026 In THROTTLED no prefetch SHALL load; demands unaffected; queue keeps filling.
REQ-027 Arbitration: demand over prefetch, except when starve counter equals STARVE_MAX and queue non-empty in RUN, prefetch wins once.
REQ-028 Starve counter SHALL increment on each demand load with queue non-empty, clear on prefetch load or empty queue.
REQ-029 drop_count_o SHALL saturate at 65535.
REQ-030 Pointers SHALL wrap modulo QDEPTH; occupancy counter width clog2(QDEPTH)+1.

Reset
REQ-031 rst SHALL asynchronously clear queue, pointers, starve counter, drop_count_o, output register (lo_valid_o=0, lo_address_o=0, lo_is_prefetch_o=0), FSM to RUN.
REQ-032 rst mid-transaction SHALL abandon the held request without completion.

Configuration
REQ-033 With PF_DEDUP_EN defined, incoming prefetch whose line address (bits above LOGLINE) matches any queued entry or held output SHALL be discarded and counted in drop_count_o.
REQ-034 Without PF_DEDUP_EN, no comparison; duplicates enqueue normally.

Structure
REQ-035 Package pf_sched_pkg SHALL hold the FSM state enum and default constants.
REQ-036 Queue SHALL be sub-module pf_request_fifo (drop-oldest FIFO with entry-match port); arbitration, FSM, output register in top.

Verification
REQ-037 Demand 0x1000 and prefetch 0x2000 same cycle, lo_ready_i=1 -> lo_address_o=0x1000 next cycle, 0x2000 following cycle, lo_is_prefetch_o=1.
REQ-038 9 prefetches 0x40..0x240 back-to-back, mshr_free_i=0 -> queue holds 0x80..0x240, drop_count_o=1.
REQ-039 mshr_free_i 1->2->3 with queue non-empty -> no prefetch at 1 or 2, issue resumes after 3.
REQ-040 Continuous demands, one queued prefetch -> prefetch issued after 15 demand grants.
REQ-041 PF_DEDUP_EN, prefetch 0x1000 then 0x1010 -> second dropped, drop_count_o=1; macro off -> both issued.
REQ-042 lo_ready_i=0 four cycles with valid held, then rst pulse -> outputs 0 immediately, queue empty.
